// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional overflow flag is enabled with `define SERIAL_ADD_OVF_EN.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; never below one bit so the counter is always a real vector.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell used as the serial arithmetic element.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial a+b+cin adder: one full-adder cell, LSB first, valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to compute the two's-complement overflow flag; otherwise ovf is 0.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             co_bit;
    logic             last;

    fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (co_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                last = (cnt == CNT_LAST);
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                sum       = res;
                cout      = carry;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at res[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        res   <= '0;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    res   <= {s_bit, res[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= co_bit;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // On the last ADD cycle the carry flop holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state == ADD && last) begin
            ovf_r <= carry ^ co_bit;
        end
    end

    always_comb begin
        ovf = (state == DONE) ? ovf_r : 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): latency, hold, reset abort, back-to-back.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t         e;
        logic [W:0]   full;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
`ifdef SERIAL_ADD_OVF_EN
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    // Accepts one operand set, checks ADD-phase outputs and latency, optionally
    // stalls in DONE for hold cycles with junk in_valid, then pops and compares.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        end
        a = op_a; b = op_b; cin = op_cin; in_valid = 1'b1;
        sb.push_back(model(op_a, op_b, op_cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < int'(W) + 10) begin
            vectors++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL add_phase: busy=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 00 0 0",
                         busy, in_ready, sum, cout, ovf);
            end
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != int'(W) || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: out_valid after %0d edges (out_valid=%b) required %0d", n, out_valid, W);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: queue empty required 1 entry");
            return;
        end
        e = sb[0];
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = ~op_a; b = op_a ^ op_b; cin = ~op_cin;
            @(posedge clk); #1;
            got = '{sum: sum, cout: cout, ovf: ovf};
            vectors++;
            if (got !== e || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_%0d: sum=%h cout=%b ovf=%b ov=%b ir=%b busy=%b required %h %b %b 1 0 0",
                         i, sum, cout, ovf, out_valid, in_ready, busy, e.sum, e.cout, e.ovf);
            end
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL result a=%h b=%h cin=%b: sum=%h cout=%b ovf=%b required %h %b %b",
                     op_a, op_b, op_cin, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff: ov=%b ir=%b busy=%b sum=%h cout=%b required 0 1 0 00 0",
                     out_valid, in_ready, busy, sum, cout);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b required 1 0 0 00 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'hAA, 8'h55, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'h80, 8'hFF, 1'b1, 0);
    endtask

    task automatic test_hold;
        run_op(8'h3C, 8'h5A, 1'b1, 5);
        repeat (2) begin
            @(posedge clk); #1;
            vectors++;
            if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL no_queue: busy=%b ir=%b ov=%b required 0 1 0", busy, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset_abort;
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b required 1 0 0 00 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < int'(W) + 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_result_%0d: ov=%b busy=%b required 0 0", i, out_valid, busy);
            end
        end
        run_op(8'hC8, 8'h64, 1'b1, 1);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom_range(1, 0)), i % 3);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        rst_n       = 1'b1;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
